// File: rtl/coin_collector_if.sv
// ----------------------------------------------------------------------------
// coin_collector_if
//   Bundles the coin-slot, selection and machine-status inputs of the coin
//   collector together with the request/refund outputs it presents to the
//   vending machine.
//
//   master : the customer/machine side (drives coins, selection, service_type)
//   slave  : the coin collector itself
//
//   Signals
//     coin_valid, coin_type        one coin per cycle (type 0 = NTD_5, 1 = NTD_1)
//     select_valid, select_item    select button (item 0 = NONE, 1 = ITEM_A)
//     service_type[1:0]            machine state: 00 OFF, 01 ON, 10 BUSY
//     coin_in_ntd5/ntd1[CNT_W]     coin counts offered during the issue phase
//     item_type_out                requested item, one cycle per transaction
//     coin_reject                  one-cycle pulse: last coin returned
//     busy                         collector is issuing / waiting for the machine
//     refund_valid, refund_ntd5/1  timeout refund pulse and its counts
// ----------------------------------------------------------------------------
interface coin_collector_if #(
    parameter int CNT_W = 2
);
    logic             coin_valid;
    logic             coin_type;
    logic             select_valid;
    logic             select_item;
    logic [1:0]       service_type;

    logic [CNT_W-1:0] coin_in_ntd5;
    logic [CNT_W-1:0] coin_in_ntd1;
    logic             item_type_out;
    logic             coin_reject;
    logic             busy;
    logic             refund_valid;
    logic [CNT_W-1:0] refund_ntd5;
    logic [CNT_W-1:0] refund_ntd1;

    modport master (
        output coin_valid, coin_type, select_valid, select_item, service_type,
        input  coin_in_ntd5, coin_in_ntd1, item_type_out, coin_reject, busy,
               refund_valid, refund_ntd5, refund_ntd1
    );

    modport slave (
        input  coin_valid, coin_type, select_valid, select_item, service_type,
        output coin_in_ntd5, coin_in_ntd1, item_type_out, coin_reject, busy,
               refund_valid, refund_ntd5, refund_ntd1
    );
endinterface

// File: rtl/coin_collector.sv
// ----------------------------------------------------------------------------
// coin_collector
//   Upstream front end of the vending machine. Accepts one coin per cycle,
//   keeps saturating NTD_5 / NTD_1 counts, latches the customer's item and
//   offers a single request (counts + item) to the machine while the machine
//   reports ON. After the request it waits for the machine to go OFF before
//   taking new coins.
//
//   Ports
//     clk     rising-edge clock
//     reset   synchronous, active-high reset (drops any held coins)
//     bus     coin_collector_if.slave (see interface header for signals)
//
//   Parameters
//     CNT_W        width of each coin count
//     MAX_COINS    per-type saturation limit (<= 2**CNT_W-1)
//     TIMEOUT_CYC  idle COLLECT cycles before an automatic refund
//
//   Optional feature
//     `define COIN_TIMEOUT_EN to enable the idle timer and refund outputs.
//     Without it COLLECT is held indefinitely and refund_* are tied to 0.
//
//   All outputs are registered.
// ----------------------------------------------------------------------------
module coin_collector #(
    parameter int CNT_W       = 2,
    parameter int MAX_COINS   = 3,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    coin_collector_if.slave      bus
);

    // Elaboration-time sanity check of the parameter set.
    if (MAX_COINS < 1 || MAX_COINS > (2**CNT_W) - 1 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("coin_collector: invalid CNT_W / MAX_COINS / TIMEOUT_CYC combination");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COLLECT   = 2'd1,
        S_ISSUE     = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [1:0]     SVC_OFF = 2'b00;
    localparam logic [1:0]     SVC_ON  = 2'b01;
    localparam logic [CNT_W:0] MAX_W   = (CNT_W + 1)'(MAX_COINS);

    // Saturating increment: the sum is formed one bit wider than the count so
    // it can be compared against the limit without wrapping. Result MSB flags
    // a coin that does not fit; the low bits are the (possibly unchanged) count.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
        if (sum <= MAX_W) begin
            return {1'b0, sum[CNT_W-1:0]};
        end
        return {1'b1, cnt};
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] ntd5_q, ntd5_d;
    logic [CNT_W-1:0] ntd1_q, ntd1_d;
    logic             item_q, item_d;

    logic [CNT_W-1:0] coin_in_ntd5_q, coin_in_ntd5_d;
    logic [CNT_W-1:0] coin_in_ntd1_q, coin_in_ntd1_d;
    logic             item_type_out_q, item_type_out_d;
    logic             coin_reject_q, coin_reject_d;
    logic             busy_q, busy_d;

    logic [CNT_W:0]   inc5, inc1;

`ifdef COIN_TIMEOUT_EN
    localparam int             TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             refund_valid_q, refund_valid_d;
    logic [CNT_W-1:0] refund_ntd5_q, refund_ntd5_d;
    logic [CNT_W-1:0] refund_ntd1_q, refund_ntd1_d;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        ntd5_d          = ntd5_q;
        ntd1_d          = ntd1_q;
        item_d          = item_q;
        item_type_out_d = 1'b0;
        coin_reject_d   = 1'b0;
        inc5            = sat_inc(ntd5_q);
        inc1            = sat_inc(ntd1_q);
`ifdef COIN_TIMEOUT_EN
        timer_d         = timer_q;
        refund_valid_d  = 1'b0;
        refund_ntd5_d   = '0;
        refund_ntd1_d   = '0;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef COIN_TIMEOUT_EN
                timer_d = '0;
`endif
                // Selections are ignored here: nothing is held yet.
                if (bus.coin_valid) begin
                    if (bus.coin_type) begin
                        ntd1_d = inc1[CNT_W-1:0];
                    end else begin
                        ntd5_d = inc5[CNT_W-1:0];
                    end
                    state_d = S_COLLECT;
                end
            end

            S_COLLECT: begin
                // A coin arriving together with the select is counted first
                // so it travels with the request.
                if (bus.coin_valid) begin
                    if (bus.coin_type) begin
                        if (inc1[CNT_W]) coin_reject_d = 1'b1;
                        else             ntd1_d = inc1[CNT_W-1:0];
                    end else begin
                        if (inc5[CNT_W]) coin_reject_d = 1'b1;
                        else             ntd5_d = inc5[CNT_W-1:0];
                    end
                end

                if (bus.select_valid && bus.select_item) begin
                    item_d  = bus.select_item;
                    state_d = S_ISSUE;
                end
`ifdef COIN_TIMEOUT_EN
                if (bus.coin_valid || bus.select_valid) begin
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    // Refund goes out with the counts we held; a coin in the
                    // refund cycle is then handled by IDLE and is kept.
                    refund_valid_d = 1'b1;
                    refund_ntd5_d  = ntd5_q;
                    refund_ntd1_d  = ntd1_q;
                    ntd5_d         = '0;
                    ntd1_d         = '0;
                    timer_d        = '0;
                    state_d        = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end

            S_ISSUE: begin
                if (bus.coin_valid) coin_reject_d = 1'b1;
                // item_type_out_q high means the machine has seen the request:
                // drop it and wait for the machine to finish.
                if (item_type_out_q) begin
                    ntd5_d  = '0;
                    ntd1_d  = '0;
                    item_d  = 1'b0;
                    state_d = S_WAIT_DONE;
                end else if (bus.service_type == SVC_ON) begin
                    item_type_out_d = item_q;
                end
            end

            S_WAIT_DONE: begin
                if (bus.coin_valid) coin_reject_d = 1'b1;
                // OFF guarantees the machine has left BUSY before the next request.
                if (bus.service_type == SVC_OFF) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d         = (state_d == S_ISSUE) || (state_d == S_WAIT_DONE);
        coin_in_ntd5_d = (state_d == S_ISSUE) ? ntd5_d : '0;
        coin_in_ntd1_d = (state_d == S_ISSUE) ? ntd1_d : '0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            ntd5_q          <= '0;
            ntd1_q          <= '0;
            item_q          <= 1'b0;
            coin_in_ntd5_q  <= '0;
            coin_in_ntd1_q  <= '0;
            item_type_out_q <= 1'b0;
            coin_reject_q   <= 1'b0;
            busy_q          <= 1'b0;
`ifdef COIN_TIMEOUT_EN
            timer_q         <= '0;
            refund_valid_q  <= 1'b0;
            refund_ntd5_q   <= '0;
            refund_ntd1_q   <= '0;
`endif
        end else begin
            state_q         <= state_d;
            ntd5_q          <= ntd5_d;
            ntd1_q          <= ntd1_d;
            item_q          <= item_d;
            coin_in_ntd5_q  <= coin_in_ntd5_d;
            coin_in_ntd1_q  <= coin_in_ntd1_d;
            item_type_out_q <= item_type_out_d;
            coin_reject_q   <= coin_reject_d;
            busy_q          <= busy_d;
`ifdef COIN_TIMEOUT_EN
            timer_q         <= timer_d;
            refund_valid_q  <= refund_valid_d;
            refund_ntd5_q   <= refund_ntd5_d;
            refund_ntd1_q   <= refund_ntd1_d;
`endif
        end
    end

    assign bus.coin_in_ntd5  = coin_in_ntd5_q;
    assign bus.coin_in_ntd1  = coin_in_ntd1_q;
    assign bus.item_type_out = item_type_out_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.busy          = busy_q;

`ifdef COIN_TIMEOUT_EN
    assign bus.refund_valid  = refund_valid_q;
    assign bus.refund_ntd5   = refund_ntd5_q;
    assign bus.refund_ntd1   = refund_ntd1_q;
`else
    assign bus.refund_valid  = 1'b0;
    assign bus.refund_ntd5   = '0;
    assign bus.refund_ntd1   = '0;
`endif

endmodule

// File: tb/tb_coin_collector.sv
module tb_coin_collector;

    localparam int CNT_W = 2;
    localparam int MAXC  = 3;
    localparam int TOUT  = 15;
`ifdef COIN_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    // Transaction phases of the reference model
    localparam int PH_IDLE    = 0;
    localparam int PH_COLLECT = 1;
    localparam int PH_ISSUE   = 2;
    localparam int PH_WAIT    = 3;

    logic clk;
    logic reset;

    coin_collector_if #(.CNT_W(CNT_W)) bus ();

    coin_collector #(
        .CNT_W      (CNT_W),
        .MAX_COINS  (MAXC),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_phase, m_n5, m_n1, m_idle;
    bit m_fired;
    // expected outputs after the current edge
    int e_c5, e_c1, e_item, e_rej, e_busy, e_rv, e_r5, e_r1;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One edge of the customer-level rules: coins are held per type up to
    // MAXC, a select moves the held coins into a request, the request is
    // offered once while the machine is ON, then the machine must go OFF.
    task automatic model_step(input bit cv, input bit ct, input bit sv, input bit si,
                              input logic [1:0] svc);
        e_rej = 0; e_rv = 0; e_r5 = 0; e_r1 = 0;
        if (reset) begin
            m_phase = PH_IDLE; m_n5 = 0; m_n1 = 0; m_idle = 0; m_fired = 0;
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    if (cv) begin
                        if (ct) m_n1 = 1; else m_n5 = 1;
                        m_phase = PH_COLLECT;
                        m_idle  = 0;
                    end
                end
                PH_COLLECT: begin
                    if (cv) begin
                        if (ct) begin
                            if (m_n1 < MAXC) m_n1 = m_n1 + 1; else e_rej = 1;
                        end else begin
                            if (m_n5 < MAXC) m_n5 = m_n5 + 1; else e_rej = 1;
                        end
                    end
                    if (sv && si) begin
                        m_phase = PH_ISSUE;
                    end else if (TIMEOUT_ON) begin
                        if (cv || sv) m_idle = 0; else m_idle = m_idle + 1;
                        if (m_idle == TOUT) begin
                            e_rv = 1; e_r5 = m_n5; e_r1 = m_n1;
                            m_n5 = 0; m_n1 = 0; m_idle = 0;
                            m_phase = PH_IDLE;
                        end
                    end
                end
                PH_ISSUE: begin
                    if (cv) e_rej = 1;
                    if (m_fired) begin
                        m_fired = 0; m_n5 = 0; m_n1 = 0;
                        m_phase = PH_WAIT;
                    end else if (svc == 2'b01) begin
                        m_fired = 1;
                    end
                end
                default: begin
                    if (cv) e_rej = 1;
                    if (svc == 2'b00) m_phase = PH_IDLE;
                end
            endcase
        end
        e_item = m_fired ? 1 : 0;
        e_busy = (m_phase == PH_ISSUE || m_phase == PH_WAIT) ? 1 : 0;
        e_c5   = (m_phase == PH_ISSUE) ? m_n5 : 0;
        e_c1   = (m_phase == PH_ISSUE) ? m_n1 : 0;
    endtask

    task automatic compare_all();
        check_val("coin_in_ntd5",  int'(bus.coin_in_ntd5),  e_c5);
        check_val("coin_in_ntd1",  int'(bus.coin_in_ntd1),  e_c1);
        check_val("item_type_out", int'(bus.item_type_out), e_item);
        check_val("coin_reject",   int'(bus.coin_reject),   e_rej);
        check_val("busy",          int'(bus.busy),          e_busy);
        check_val("refund_valid",  int'(bus.refund_valid),  e_rv);
        check_val("refund_ntd5",   int'(bus.refund_ntd5),   e_r5);
        check_val("refund_ntd1",   int'(bus.refund_ntd1),   e_r1);
    endtask

    task automatic step(input bit cv, input bit ct, input bit sv, input bit si,
                        input logic [1:0] svc);
        bus.coin_valid   = cv;
        bus.coin_type    = ct;
        bus.select_valid = sv;
        bus.select_item  = si;
        bus.service_type = svc;
        @(posedge clk);
        model_step(cv, ct, sv, si, svc);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'b00);
        reset = 1'b0;
    endtask

    // Keep offering ON until the item pulse is observed, bounded by budget.
    task automatic run_until_item(input int budget);
        int n;
        n = 0;
        while (bus.item_type_out !== 1'b1 && n < budget) begin
            step(0, 0, 0, 0, 2'b01);
            n++;
        end
        check_val("item_seen", int'(bus.item_type_out), 1);
    endtask

    // Finish a transaction whose item pulse is currently visible.
    task automatic finish_txn();
        step(0, 0, 0, 0, 2'b10);
        check_val("item_cleared", int'(bus.item_type_out), 0);
        step(0, 0, 0, 0, 2'b00);
        check_val("busy_after_off", int'(bus.busy), 0);
    endtask

    int pulses;
    int first_rv;
    int r5;

    initial begin
        bus.coin_valid   = 1'b0;
        bus.coin_type    = 1'b0;
        bus.select_valid = 1'b0;
        bus.select_item  = 1'b0;
        bus.service_type = 2'b00;
        reset            = 1'b1;

        // Reset and basic transaction: 2x NTD_5, 1x NTD_1, select ITEM_A
        do_reset(2);
        check_val("reset_busy", int'(bus.busy), 0);
        step(1, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        step(1, 1, 0, 0, 2'b00);
        step(0, 0, 1, 1, 2'b01);
        run_until_item(10);
        check_val("t1_ntd5", int'(bus.coin_in_ntd5), 2);
        check_val("t1_ntd1", int'(bus.coin_in_ntd1), 1);
        check_val("t1_busy", int'(bus.busy), 1);
        finish_txn();

        // Saturation: 4x NTD_1, reject only after the 4th
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 2'b00);
            if (bus.coin_reject) pulses++;
        end
        check_val("t2_reject_last", int'(bus.coin_reject), 1);
        check_val("t2_reject_count", pulses, 1);
        step(0, 0, 1, 1, 2'b10);
        run_until_item(10);
        check_val("t2_ntd1_sat", int'(bus.coin_in_ntd1), 3);
        finish_txn();

        // Machine BUSY for 5 cycles, then ON: exactly one item pulse
        step(1, 0, 0, 0, 2'b10);
        step(0, 0, 1, 1, 2'b10);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 2'b10);
            if (bus.item_type_out) pulses++;
        end
        check_val("t3_no_item_busy", pulses, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 2'b01);
            if (bus.item_type_out) pulses++;
        end
        check_val("t3_one_item", pulses, 1);
        step(0, 0, 0, 0, 2'b00);
        check_val("t3_idle", int'(bus.busy), 0);

        // Coin during WAIT_DONE is rejected and not counted
        step(1, 1, 0, 0, 2'b00);
        step(0, 0, 1, 1, 2'b01);
        run_until_item(10);
        step(0, 0, 0, 0, 2'b10);
        step(1, 0, 0, 0, 2'b10);
        check_val("t4_wait_reject", int'(bus.coin_reject), 1);
        check_val("t4_wait_ntd5", int'(bus.coin_in_ntd5), 0);
        step(0, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        check_val("t4_new_coin_ok", int'(bus.coin_reject), 0);
        // Coin + select in the same cycle, one NTD_5 already held
        step(1, 0, 1, 1, 2'b10);
        run_until_item(10);
        check_val("t5_ntd5", int'(bus.coin_in_ntd5), 2);
        finish_txn();

        // Idle timeout / no refund
        step(1, 0, 0, 0, 2'b00);
        first_rv = -1;
        r5       = 0;
        for (int i = 1; i <= 100; i++) begin
            step(0, 0, 0, 0, 2'b00);
            if (bus.refund_valid && first_rv < 0) begin
                first_rv = i;
                r5       = int'(bus.refund_ntd5);
            end
        end
`ifdef COIN_TIMEOUT_EN
        check_val("t6_refund_cycle", first_rv, 15);
        check_val("t6_refund_ntd5", r5, 1);
        // Coin arriving in the refund cycle is kept as a fresh IDLE coin
        step(1, 1, 0, 0, 2'b00);
        for (int i = 1; i < 15; i++) step(0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 0, 2'b00);
        check_val("t6_refund2", int'(bus.refund_valid), 1);
        step(1, 1, 0, 0, 2'b00);
        step(0, 0, 1, 1, 2'b01);
        run_until_item(10);
        check_val("t6_kept_ntd1", int'(bus.coin_in_ntd1), 1);
        check_val("t6_kept_ntd5", int'(bus.coin_in_ntd5), 0);
`else
        check_val("t6_no_refund", first_rv, -1);
`endif
        do_reset(2);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 2, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 2)));
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
